// File: rtl/rtu_hdr_snoop.sv
// Passive per-port header snooper: watches the RX fabric stream, extracts DMAC/SMAC/802.1Q tag
// and issues one RTU lookup request per complete frame header, never stalling the fabric.
module rtu_hdr_snoop #(
  parameter int g_mac_addr_width = 48,
  parameter int g_vid_width      = 12,
  parameter int g_prio_width     = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [15:0]                 snk_data_i,
  input  logic                        snk_valid_i,
  input  logic                        snk_sof_i,
  input  logic                        snk_eof_i,
  input  logic                        snk_error_i,
  input  logic                        port_en_i,
  input  logic                        rtu_full_i,
  output logic                        rtu_rq_valid_o,
  output logic [g_mac_addr_width-1:0] rtu_rq_dmac_o,
  output logic [g_mac_addr_width-1:0] rtu_rq_smac_o,
  output logic [g_vid_width-1:0]      rtu_rq_vid_o,
  output logic                        rtu_rq_has_vid_o,
  output logic [g_prio_width-1:0]     rtu_rq_prio_o,
  output logic                        rtu_rq_has_prio_o,
  output logic                        rtu_rq_drop_o,
  output logic [15:0]                 ovf_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_TAG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TPID_8021Q = 16'h8100;
  localparam logic [2:0]  ETYPE_WORD = 3'd6;

  state_t                      state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [g_mac_addr_width-1:0] dmac_cap_q, smac_cap_q;

  logic                        lat;
  logic                        lat_tagged;
  logic                        issue;

  logic                        pend_q, pend_d;
  logic [g_mac_addr_width-1:0] dmac_q, dmac_d;
  logic [g_mac_addr_width-1:0] smac_q, smac_d;
  logic [g_vid_width-1:0]      vid_q, vid_d;
  logic                        has_vid_q, has_vid_d;
  logic [g_prio_width-1:0]     prio_q, prio_d;
  logic                        has_prio_q, has_prio_d;
  logic                        drop_q, drop_d;
  logic [15:0]                 ovf_q, ovf_d;

  logic                        cap_en;
  logic [2:0]                  cap_idx;
  logic [g_vid_width-1:0]      tci_vid;
  logic [g_prio_width-1:0]     tci_prio;

  assign tci_vid  = snk_data_i[g_vid_width-1:0];
  assign tci_prio = snk_data_i[15 -: g_prio_width];

  // Header framing FSM: sof always restarts capture from word 0, whatever the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat        = 1'b0;
    lat_tagged = 1'b0;
    if (snk_valid_i) begin
      if (snk_sof_i) begin
        cnt_d   = 3'd1;
        state_d = (snk_eof_i || snk_error_i) ? S_IDLE : S_HDR;
      end else begin
        case (state_q)
          S_HDR: begin
            if (cnt_q == ETYPE_WORD) begin
              if (snk_error_i) begin
                state_d = S_IDLE;
              end else if (snk_data_i == TPID_8021Q) begin
                state_d = snk_eof_i ? S_IDLE : S_TAG;
              end else begin
                lat     = 1'b1;
                state_d = snk_eof_i ? S_IDLE : S_DONE;
              end
            end else if (snk_eof_i || snk_error_i) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          S_TAG: begin
            if (snk_error_i) begin
              state_d = S_IDLE;
            end else begin
              lat        = 1'b1;
              lat_tagged = 1'b1;
              state_d    = snk_eof_i ? S_IDLE : S_DONE;
            end
          end
          S_DONE: begin
            if (snk_eof_i || snk_error_i) begin
              state_d = S_IDLE;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address words 0..5 land in the capture registers; only control is reset here.
  assign cap_en  = snk_valid_i && (snk_sof_i || (state_q == S_HDR));
  assign cap_idx = snk_sof_i ? 3'd0 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (cap_en) begin
      case (cap_idx)
        3'd0:    dmac_cap_q[47:32] <= snk_data_i;
        3'd1:    dmac_cap_q[31:16] <= snk_data_i;
        3'd2:    dmac_cap_q[15:0]  <= snk_data_i;
        3'd3:    smac_cap_q[47:32] <= snk_data_i;
        3'd4:    smac_cap_q[31:16] <= snk_data_i;
        3'd5:    smac_cap_q[15:0]  <= snk_data_i;
        default: ;
      endcase
    end
  end

  // A request issued this cycle frees the slot, so a same-edge latch reloads without overflow.
  assign issue = pend_q && !rtu_full_i;

  always_comb begin
    pend_d     = pend_q && !issue;
    dmac_d     = dmac_q;
    smac_d     = smac_q;
    vid_d      = vid_q;
    has_vid_d  = has_vid_q;
    prio_d     = prio_q;
    has_prio_d = has_prio_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    if (lat) begin
      if (pend_d) begin
        if (ovf_q != 16'hFFFF) begin
          ovf_d = ovf_q + 16'd1;
        end
      end else begin
        pend_d     = 1'b1;
        dmac_d     = dmac_cap_q;
        smac_d     = smac_cap_q;
        drop_d     = !port_en_i;
        has_prio_d = lat_tagged;
        prio_d     = lat_tagged ? tci_prio : '0;
        vid_d      = lat_tagged ? tci_vid : '0;
        has_vid_d  = lat_tagged && (tci_vid != '0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      dmac_q     <= '0;
      smac_q     <= '0;
      vid_q      <= '0;
      has_vid_q  <= 1'b0;
      prio_q     <= '0;
      has_prio_q <= 1'b0;
      drop_q     <= 1'b0;
      ovf_q      <= 16'd0;
    end else begin
      pend_q     <= pend_d;
      dmac_q     <= dmac_d;
      smac_q     <= smac_d;
      vid_q      <= vid_d;
      has_vid_q  <= has_vid_d;
      prio_q     <= prio_d;
      has_prio_q <= has_prio_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rtu_rq_valid_o    = issue;
  assign rtu_rq_dmac_o     = dmac_q;
  assign rtu_rq_smac_o     = smac_q;
  assign rtu_rq_vid_o      = vid_q;
  assign rtu_rq_has_vid_o  = has_vid_q;
  assign rtu_rq_prio_o     = prio_q;
  assign rtu_rq_has_prio_o = has_prio_q;
  assign rtu_rq_drop_o     = drop_q;
  assign ovf_cnt_o         = ovf_q;

endmodule
